traffic_cmd_parser: RTL and testbench



---
 rtl/traffic_cmd_parser_pkg.sv | 29 ++
 rtl/traffic_cmd_parser_if.sv | 25 ++
 rtl/traffic_cmd_parser_cmd_timeout_cnt.sv | 22 ++
 rtl/traffic_cmd_parser.sv | 116 +++++++++++
 tb/tb_traffic_cmd_parser.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/traffic_cmd_parser_pkg.sv
// traffic_cmd_pkg: command types, parser states and defaults shared by the traffic command parser.
// Optional 5-byte checksummed frames are enabled by TRAFFIC_CMD_CHECKSUM_EN.
package traffic_cmd_pkg;

    typedef enum logic [2:0] {
        CMD_RUN        = 3'd0,
        CMD_OFF        = 3'd1,
        CMD_FREE       = 3'd2,
        CMD_SET_GREEN  = 3'd3,
        CMD_SET_RED    = 3'd4,
        CMD_SET_YELLOW = 3'd5
    } cmd_type_e;

    localparam logic [2:0] CMD_TYPE_MAX = 3'd5;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_GET_TYPE,
        ST_GET_DHI,
        ST_GET_DLO,
`ifdef TRAFFIC_CMD_CHECKSUM_EN
        ST_GET_CHK,
`endif
        ST_EMIT
    } parser_state_e;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/traffic_cmd_parser_if.sv
// traffic_cmd_parser_if: byte-stream input and command/error outputs of the command parser.
interface traffic_cmd_parser_if
    import traffic_cmd_pkg::*;
#(
    parameter int ERR_CNT_W = 8
);
    logic [7:0]           byte_data_i;
    logic                 byte_valid_i;
    logic                 byte_ready_o;
    cmd_type_e            cmd_type_o;
    logic                 cmd_valid_o;
    logic [15:0]          cmd_data_o;
    logic                 frame_err_o;
    logic [ERR_CNT_W-1:0] err_cnt_o;

    modport master (
        output byte_data_i, byte_valid_i,
        input  byte_ready_o, cmd_type_o, cmd_valid_o, cmd_data_o, frame_err_o, err_cnt_o
    );

    modport slave (
        input  byte_data_i, byte_valid_i,
        output byte_ready_o, cmd_type_o, cmd_valid_o, cmd_data_o, frame_err_o, err_cnt_o
    );
endinterface

// File: rtl/traffic_cmd_parser_cmd_timeout_cnt.sv
// cmd_timeout_cnt: clearable inter-byte gap counter; expired is high once the count reaches TIMEOUT_CYCLES-1.
module cmd_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 200
) (
    input  logic clk_i,
    input  logic arstn_i,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT_CYCLES + 1);

    logic [W-1:0] cnt;

    assign expired = cnt == W'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en && !expired) cnt <= cnt + W'(1);
    end
endmodule

// File: rtl/traffic_cmd_parser.sv
// traffic_cmd_parser: validates SYNC/TYPE/DATA frames and strobes commands to the traffic controller.
// Define TRAFFIC_CMD_CHECKSUM_EN to require a trailing CHK = TYPE ^ DATA_HI ^ DATA_LO byte.
module traffic_cmd_parser
    import traffic_cmd_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 200,
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int         ERR_CNT_W      = 8
) (
    input logic                 clk_i,
    input logic                 arstn_i,
    traffic_cmd_parser_if.slave bus
);
    parser_state_e        state_q, state_d;
    cmd_type_e            type_q, cmd_type_q;
    logic [7:0]           dhi_q;
    logic [15:0]          cmd_data_q, data_new;
    logic [ERR_CNT_W-1:0] err_cnt_q;
    logic                 frame_err_q;
    logic                 ready, accept, in_get, expired, err, load, type_bad;
    logic [7:0]           b;

    assign b        = bus.byte_data_i;
    assign ready    = arstn_i && state_q != ST_EMIT;
    assign accept   = bus.byte_valid_i && ready;
    assign in_get   = state_q != ST_HUNT && state_q != ST_EMIT;
    assign type_bad = b > {5'd0, CMD_TYPE_MAX};

`ifdef TRAFFIC_CMD_CHECKSUM_EN
    logic [7:0] dlo_q;
    assign data_new = {dhi_q, dlo_q};
`else
    assign data_new = {dhi_q, b};
`endif

    assign bus.byte_ready_o = ready;
    assign bus.cmd_valid_o  = state_q == ST_EMIT;
    assign bus.cmd_type_o   = cmd_type_q;
    assign bus.cmd_data_o   = cmd_data_q;
    assign bus.frame_err_o  = frame_err_q;
    assign bus.err_cnt_o    = err_cnt_q;

    cmd_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk_i   (clk_i),
        .arstn_i (arstn_i),
        .clr     (accept || !in_get),
        .en      (in_get),
        .expired (expired)
    );

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) state_q <= ST_HUNT;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        err     = 1'b0;
        load    = 1'b0;
        case (state_q)
            ST_HUNT:     if (accept && b == SYNC_BYTE) state_d = ST_GET_TYPE;
            ST_GET_TYPE: if (accept) begin
                err     = type_bad;
                state_d = type_bad ? ST_HUNT : ST_GET_DHI;
            end
            ST_GET_DHI:  if (accept) state_d = ST_GET_DLO;
`ifdef TRAFFIC_CMD_CHECKSUM_EN
            ST_GET_DLO:  if (accept) state_d = ST_GET_CHK;
            ST_GET_CHK:  if (accept) begin
                load    = b == ({5'd0, type_q} ^ data_new[15:8] ^ data_new[7:0]);
                err     = !load;
                state_d = load ? ST_EMIT : ST_HUNT;
            end
`else
            ST_GET_DLO:  if (accept) begin
                load    = 1'b1;
                state_d = ST_EMIT;
            end
`endif
            ST_EMIT:     state_d = ST_HUNT;
            default:     state_d = ST_HUNT;
        endcase
        // an accepted byte always wins over a timeout in the same cycle
        if (in_get && expired && !accept) begin
            err     = 1'b1;
            state_d = ST_HUNT;
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            type_q      <= CMD_RUN;
            dhi_q       <= '0;
            cmd_type_q  <= CMD_RUN;
            cmd_data_q  <= '0;
            frame_err_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            if (accept && state_q == ST_GET_TYPE && !type_bad) type_q <= cmd_type_e'(b[2:0]);
            if (accept && state_q == ST_GET_DHI) dhi_q <= b;
            if (load) begin
                cmd_type_q <= type_q;
                cmd_data_q <= data_new;
            end
            frame_err_q <= err;
            if (err && !(&err_cnt_q)) err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
        end
    end

`ifdef TRAFFIC_CMD_CHECKSUM_EN
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) dlo_q <= '0;
        else if (accept && state_q == ST_GET_DLO) dlo_q <= b;
    end
`endif
endmodule

// File: tb/tb_traffic_cmd_parser.sv
// tb_traffic_cmd_parser: directed and random byte streams checked against a frame-level reference model.
module tb_traffic_cmd_parser;
    import traffic_cmd_pkg::*;

    localparam int         T     = 200;
    localparam logic [7:0] SYNC  = 8'hA5;
    localparam int         CMAX  = 255;
`ifdef TRAFFIC_CMD_CHECKSUM_EN
    localparam int         FLEN  = 5;
`else
    localparam int         FLEN  = 4;
`endif

    typedef struct {
        logic [7:0] b;
        int         gap;
    } item_t;

    logic clk_i = 1'b0;
    logic arstn_i = 1'b0;
    int   n_checks = 0;
    int   n_errs = 0;

    item_t      stream[$];
    logic [7:0] fr[$];
    int         m_idle;
    logic       m_emit, m_err, m_acc;
    logic [2:0] m_type;
    logic [15:0] m_data;
    int         m_cnt;

    traffic_cmd_parser_if #(.ERR_CNT_W(8)) bus ();

    traffic_cmd_parser #(.TIMEOUT_CYCLES(T), .SYNC_BYTE(SYNC), .ERR_CNT_W(8)) dut (
        .clk_i   (clk_i),
        .arstn_i (arstn_i),
        .bus     (bus.slave)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        fr.delete();
        m_idle = 0;
        m_emit = 1'b0;
        m_err  = 1'b0;
        m_type = '0;
        m_data = '0;
        m_cnt  = 0;
    endtask

    task automatic model_bad();
        m_err = 1'b1;
        fr.delete();
        m_idle = 0;
        if (m_cnt < CMAX) m_cnt++;
    endtask

    // Frame-level view: collect accepted bytes of the current frame and judge it when complete.
    task automatic model_step(input logic acc, input logic [7:0] b);
        m_err = 1'b0;
        if (m_emit) m_emit = 1'b0;
        else if (acc) begin
            m_idle = 0;
            if (fr.size() == 0) begin
                if (b == SYNC) fr.push_back(b);
            end else begin
                fr.push_back(b);
                if (fr.size() == 2 && b > 8'd5) model_bad();
                else if (fr.size() == FLEN) begin
`ifdef TRAFFIC_CMD_CHECKSUM_EN
                    if (b != (fr[1] ^ fr[2] ^ fr[3])) model_bad();
                    else begin
`else
                    begin
`endif
                        m_emit = 1'b1;
                        m_type = fr[1][2:0];
                        m_data = {fr[2], fr[3]};
                        fr.delete();
                    end
                end
            end
        end else if (fr.size() > 0) begin
            m_idle++;
            if (m_idle == T) model_bad();
        end
    endtask

    task automatic cycle();
        @(negedge clk_i);
        check("ready", 32'(bus.byte_ready_o), 32'(!m_emit));
        check("cmd_valid", 32'(bus.cmd_valid_o), 32'(m_emit));
        check("cmd_type", 32'(bus.cmd_type_o), 32'(m_type));
        check("cmd_data", 32'(bus.cmd_data_o), 32'(m_data));
        check("frame_err", 32'(bus.frame_err_o), 32'(m_err));
        check("err_cnt", 32'(bus.err_cnt_o), 32'(m_cnt));
        m_acc = bus.byte_valid_i && !m_emit;
        @(posedge clk_i);
        model_step(m_acc, bus.byte_data_i);
        #1;
    endtask

    task automatic push(input logic [7:0] b, input int gap = 0);
        stream.push_back('{b: b, gap: gap});
    endtask

    task automatic push_frame(input logic [7:0] t, input logic [7:0] dhi, input logic [7:0] dlo,
                              input int gap = 0, input logic [7:0] chk_flip = 8'h00);
        push(SYNC, gap);
        push(t);
        push(dhi);
        push(dlo);
`ifdef TRAFFIC_CMD_CHECKSUM_EN
        push(t ^ dhi ^ dlo ^ chk_flip);
`else
        if (chk_flip != 8'h00) push(8'h00);
`endif
    endtask

    task automatic run();
        while (stream.size() > 0) begin
            if (stream[0].gap > 0) begin
                bus.byte_valid_i = 1'b0;
                stream[0].gap = stream[0].gap - 1;
                cycle();
            end else begin
                bus.byte_valid_i = 1'b1;
                bus.byte_data_i  = stream[0].b;
                cycle();
                if (m_acc) void'(stream.pop_front());
            end
        end
        bus.byte_valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.byte_valid_i = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(bus.byte_ready_o), 32'd0);
        check({tag, "_valid"}, 32'(bus.cmd_valid_o), 32'd0);
        check({tag, "_type"}, 32'(bus.cmd_type_o), 32'd0);
        check({tag, "_data"}, 32'(bus.cmd_data_o), 32'd0);
        check({tag, "_err"}, 32'(bus.frame_err_o), 32'd0);
        check({tag, "_cnt"}, 32'(bus.err_cnt_o), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.byte_valid_i = 1'b0;
        bus.byte_data_i  = 8'h00;
        model_reset();
        #2;
        check_reset_outputs("rst");
        repeat (2) @(posedge clk_i);
        #1;
        arstn_i = 1'b1;

        push_frame(8'h03, 8'h01, 8'hF4);
        run();
        idle(3);

        push(8'h00);
        push(8'hFF);
        push_frame(8'h01, 8'h00, 8'h00);
        run();
        idle(3);

        push(SYNC);
        push(8'h07);
        run();
        idle(3);

        push(SYNC);
        push(8'h04);
        push(8'h01, T - 1);
        push(8'hF4);
`ifdef TRAFFIC_CMD_CHECKSUM_EN
        push(8'h04 ^ 8'h01 ^ 8'hF4);
`endif
        run();
        idle(3);

        push(SYNC);
        push(8'h04);
        push(8'h01, T);
        push(8'hF4);
        run();
        idle(3);

        for (int i = 0; i < 300; i++) begin
            push(SYNC);
            push(8'($urandom_range(6, 255)));
        end
        run();
        idle(2);

        push_frame(8'h05, 8'h00, 8'h64);
        push_frame(8'h05, 8'h00, 8'h64, 0, 8'h01);
        run();
        idle(3);

        push(SYNC);
        push(8'h03);
        push(8'h01);
        run();
        arstn_i = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        model_reset();
        @(posedge clk_i);
        #1;
        arstn_i = 1'b1;
        push(8'h64);
        run();
        idle(3);

        for (int i = 0; i < 400; i++) begin
            int r, g;
            r = int'($urandom_range(0, 99));
            g = ($urandom_range(0, 99) < 3) ? int'($urandom_range(T - 5, T + 5)) : int'($urandom_range(0, 2));
            if (r < 10) push(8'($urandom), g);
            else push_frame(($urandom_range(0, 99) < 15) ? 8'($urandom_range(6, 255)) : 8'($urandom_range(0, 5)),
                            8'($urandom), 8'($urandom), g,
                            ($urandom_range(0, 99) < 10) ? 8'($urandom_range(1, 255)) : 8'h00);
        end
        run();
        idle(5);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end
endmodule
